muldiv_seq: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide operations, sharing the ALU control encoding (MULH 5'b01100, MUL 5'b01101, MULHSU 5'b01110, MULHU 5'b01111, DIV 5'b10000, DIVU 5'b10001, REM 5'b10010, REMU 5'b10011). It replaces single-cycle combinational M-extension logic with a 1-bit-per-cycle shift-add multiplier and restoring divider. The core launches an operation with a start pulse and stalls while busy. The result is captured on the done pulse.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_step.sv | 31 +++
 rtl/muldiv_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multi-cycle multiply/divide sequencer:
// ALU control codes for the M operations, FSM state encoding and the
// iteration count of the bit-serial datapath.
package muldiv_pkg;

  // M-extension operation codes, identical to the ALU decoder encoding
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MUL    = 5'b01101;
  localparam logic [4:0] OP_MULHSU = 5'b01110;
  localparam logic [4:0] OP_MULHU  = 5'b01111;
  localparam logic [4:0] OP_DIV    = 5'b10000;
  localparam logic [4:0] OP_DIVU   = 5'b10001;
  localparam logic [4:0] OP_REM    = 5'b10010;
  localparam logic [4:0] OP_REMU   = 5'b10011;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // One result bit per cycle, 32 cycles per operation
  localparam int         ITER_COUNT = 32'sd32;
  localparam logic [4:0] LAST_ITER  = 5'(ITER_COUNT - 32'sd1);

  // True for any of the eight M-extension codes
  function automatic logic is_m_op(input logic [4:0] code);
    is_m_op = (code >= OP_MULH) && (code <= OP_REMU);
  endfunction

  // True for the divide/remainder group (only meaningful for M codes)
  function automatic logic is_div_op(input logic [4:0] code);
    is_div_op = (code >= OP_DIV) && (code <= OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the bit-serial datapath, built around a single shared
// adder. Multiply: conditionally add the multiplicand into the accumulator
// upper half. Divide: trial-subtract the divisor from the shifted partial
// remainder and produce the quotient bit (restore when negative).
module muldiv_step #(
  parameter int W = 33
) (
  input  logic         is_div,
  input  logic         add_en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         q_bit
);

  logic [W-1:0] sum_s;

  // Shared adder: a + b for multiply, a + ~b + 1 (= a - b) for divide
  always_comb begin
    sum_s = a + (is_div ? ~b : b) + {{(W-1){1'b0}}, is_div};
    if (is_div) begin
      // Non-negative difference means the divisor fits: keep it, set bit
      q_bit = ~sum_s[W-1];
      y     = q_bit ? sum_s : a;
    end else begin
      q_bit = 1'b0;
      y     = add_en ? sum_s : a;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: shift-add multiplier and restoring divider
// producing one bit per cycle, with launch-time magnitude conversion,
// fast paths for divide-by-zero / signed overflow, and a final sign fix.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      ctrl,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  // Accumulator layout: multiply {hi[XLEN:0], lo[XLEN-1:0]},
  // divide {rem[XLEN:0], quot[XLEN-1:0]}; both start as {0, |op1|}.
  localparam int AW = 2 * XLEN + 1;

  localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_W = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_W  = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_r, state_nxt_s;
  logic [4:0]      cnt_r, cnt_nxt_s;
  logic [AW-1:0]   acc_r, acc_nxt_s;
  logic [XLEN-1:0] mag2_r, mag2_nxt_s;
  logic [4:0]      ctrl_r, ctrl_nxt_s;
  logic            neg_r, neg_nxt_s;
  logic [XLEN-1:0] res_r, res_nxt_s;
  logic            busy_r, done_r;

  logic            l_sgn1_s, l_sgn2_s, l_neg_s, l_fast_s;
  logic [XLEN-1:0] l_mag1_s, l_mag2_s, l_fast_res_s;

  logic            step_div_s, step_en_s, step_q_s;
  logic [XLEN:0]   step_a_s, step_b_s, step_y_s;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, fix_res_s;

  // Launch decode: operand signedness, magnitudes and result sign
  always_comb begin
    l_sgn1_s = 1'b0;
    l_sgn2_s = 1'b0;
    l_neg_s  = 1'b0;
    case (ctrl)
      OP_MUL, OP_MULH, OP_DIV: begin
        l_sgn1_s = op1[XLEN-1];
        l_sgn2_s = op2[XLEN-1];
        l_neg_s  = op1[XLEN-1] ^ op2[XLEN-1];
      end
      OP_REM: begin
        l_sgn1_s = op1[XLEN-1];
        l_sgn2_s = op2[XLEN-1];
        l_neg_s  = op1[XLEN-1];
      end
      OP_MULHSU: begin
        l_sgn1_s = op1[XLEN-1];
        l_neg_s  = op1[XLEN-1];
      end
      default: begin
        l_sgn1_s = 1'b0;
        l_sgn2_s = 1'b0;
        l_neg_s  = 1'b0;
      end
    endcase
    // Negating 0x80000000 wraps to itself, read back as unsigned 2^31
    if (l_sgn1_s) begin
      l_mag1_s = -op1;
    end else begin
      l_mag1_s = op1;
    end
    if (l_sgn2_s) begin
      l_mag2_s = -op2;
    end else begin
      l_mag2_s = op2;
    end
  end

  // Launch fast paths that complete without iterating
  always_comb begin
    l_fast_s     = 1'b0;
    l_fast_res_s = ZERO_W;
    if (!is_m_op(ctrl)) begin
      l_fast_s     = 1'b1;
      l_fast_res_s = ZERO_W;
    end else if (is_div_op(ctrl) && (op2 == ZERO_W)) begin
      l_fast_s     = 1'b1;
      l_fast_res_s = ((ctrl == OP_DIV) || (ctrl == OP_DIVU)) ? ONES_W : op1;
    end else if (((ctrl == OP_DIV) || (ctrl == OP_REM)) &&
                 (op1 == MIN_W) && (op2 == ONES_W)) begin
      l_fast_s     = 1'b1;
      l_fast_res_s = (ctrl == OP_DIV) ? MIN_W : ZERO_W;
    end else begin
      l_fast_s     = 1'b0;
      l_fast_res_s = ZERO_W;
    end
  end

  // Step operand selection from the working registers
  always_comb begin
    step_div_s = is_div_op(ctrl_r);
    step_en_s  = acc_r[0];
    step_b_s   = {1'b0, mag2_r};
    if (step_div_s) begin
      // {rem, quot} shifted left by one: partial remainder plus next dividend bit
      step_a_s = acc_r[2*XLEN-1:XLEN-1];
    end else begin
      step_a_s = acc_r[AW-1:XLEN];
    end
  end

  muldiv_step #(
    .W(XLEN + 1)
  ) u_step (
    .is_div (step_div_s),
    .add_en (step_en_s),
    .a      (step_a_s),
    .b      (step_b_s),
    .y      (step_y_s),
    .q_bit  (step_q_s)
  );

  // Sign correction and result selection for the FIX state
  always_comb begin
    if (neg_r) begin
      prod_s = -acc_r[2*XLEN-1:0];
      quot_s = -acc_r[XLEN-1:0];
      rem_s  = -acc_r[2*XLEN-1:XLEN];
    end else begin
      prod_s = acc_r[2*XLEN-1:0];
      quot_s = acc_r[XLEN-1:0];
      rem_s  = acc_r[2*XLEN-1:XLEN];
    end
    case (ctrl_r)
      OP_MUL:                        fix_res_s = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res_s = quot_s;
      OP_REM, OP_REMU:               fix_res_s = rem_s;
      default:                       fix_res_s = ZERO_W;
    endcase
  end

  // Next-state and datapath next values; kill overrides everything
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    acc_nxt_s   = acc_r;
    mag2_nxt_s  = mag2_r;
    ctrl_nxt_s  = ctrl_r;
    neg_nxt_s   = neg_r;
    res_nxt_s   = res_r;
    if (kill) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = 5'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start && l_fast_s) begin
            state_nxt_s = ST_DONE;
            res_nxt_s   = l_fast_res_s;
          end else if (start) begin
            state_nxt_s = ST_CALC;
            cnt_nxt_s   = 5'd0;
            acc_nxt_s   = {{(XLEN+1){1'b0}}, l_mag1_s};
            mag2_nxt_s  = l_mag2_s;
            ctrl_nxt_s  = ctrl;
            neg_nxt_s   = l_neg_s;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (step_div_s) begin
            acc_nxt_s = {step_y_s, acc_r[XLEN-2:0], step_q_s};
          end else begin
            acc_nxt_s = {1'b0, step_y_s, acc_r[XLEN-1:1]};
          end
          cnt_nxt_s = cnt_r + 5'd1;
          if (cnt_r == LAST_ITER) begin
            state_nxt_s = ST_FIX;
          end else begin
            state_nxt_s = ST_CALC;
          end
        end
        ST_FIX: begin
          res_nxt_s   = fix_res_s;
          state_nxt_s = ST_DONE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, working registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
      acc_r   <= {AW{1'b0}};
      mag2_r  <= ZERO_W;
      ctrl_r  <= 5'd0;
      neg_r   <= 1'b0;
      res_r   <= ZERO_W;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      acc_r   <= acc_nxt_s;
      mag2_r  <= mag2_nxt_s;
      ctrl_r  <= ctrl_nxt_s;
      neg_r   <= neg_nxt_s;
      res_r   <= res_nxt_s;
      busy_r  <= (state_nxt_s == ST_CALC) || (state_nxt_s == ST_FIX);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign res  = res_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  ctrl;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int checks;
  int errors;

  muldiv_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ctrl  (ctrl),
    .op1   (op1),
    .op2   (op2),
    .kill  (kill),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op and wait for done; optionally poke a start while busy
  task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int exp_busy, input int poke);
    int lat;
    int bcnt;
    bit seen;
    ctrl  = c;
    op1   = a;
    op2   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    bcnt  = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
      if (lat == poke) begin
        start = 1'b1;
        ctrl  = OP_MUL;
        op1   = 32'd7;
        op2   = 32'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(bcnt), 32'(exp_busy));
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) cnt++;
    end
  endtask

  initial begin
    int nd;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    kill   = 1'b0;
    ctrl   = 5'd0;
    op1    = 32'd0;
    op2    = 32'd0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_res", res, 32'd0);
    reset = 1'b0;
    tick();

    // Full-latency operations
    run_op("mul", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 33, 0); tick();
    run_op("mulh", OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 34, 33, 0); tick();
    run_op("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 33, 0); tick();
    run_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 33, 0); tick();
    run_op("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 33, 0); tick();
    run_op("rem", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 33, 0); tick();
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 33, 0); tick();
    run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 34, 33, 0); tick();

    // Fast paths and non-M code
    run_op("div0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0, 0); tick();
    run_op("remu0", OP_REMU, 32'd5, 32'd0, 32'd5, 1, 0, 0); tick();
    run_op("divovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 0); tick();
    run_op("nonm", 5'b00000, 32'd9, 32'd9, 32'd0, 1, 0, 0); tick();
    run_op("removf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0, 0); tick();

    // Start while busy is ignored
    run_op("ign", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 33, 5);
    count_dones(40, nd);
    check("ign_nodone", 32'(nd), 32'd0);

    // Back-to-back: second start lands in the first op's done cycle
    run_op("b2b1", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 33, 0);
    run_op("b2b2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 33, 0);
    tick();

    // Kill mid-CALC: no done, result keeps previous value
    ctrl  = OP_MULHU;
    op1   = 32'hFFFFFFFF;
    op2   = 32'hFFFFFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("kill_pre_busy", {31'd0, busy}, 32'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_done", {31'd0, done}, 32'd0);
    check("kill_res", res, 32'hFFFFFFFD);
    count_dones(40, nd);
    check("kill_nodone", 32'(nd), 32'd0);

    // Kill and start together: start dropped
    ctrl  = OP_DIV;
    op1   = 32'd5;
    op2   = 32'd0;
    start = 1'b1;
    kill  = 1'b1;
    tick();
    start = 1'b0;
    kill  = 1'b0;
    check("ks_done", {31'd0, done}, 32'd0);
    check("ks_busy", {31'd0, busy}, 32'd0);
    check("ks_res", res, 32'hFFFFFFFD);

    // Reset mid-operation
    ctrl  = OP_MUL;
    op1   = 32'd3;
    op2   = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_res", res, 32'd0);
    count_dones(40, nd);
    check("mrst_nodone", 32'(nd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
